hazard_stall_unit: RTL and testbench

//  Issue-side partner of the operand forwarding logic. Detects hazards that forwarding

---
 rtl/hazard_stall_unit_pkg.sv | 46 ++++
 rtl/hazard_stall_unit_reg_scoreboard.sv | 48 ++++
 rtl/hazard_stall_unit.sv | 116 +++++++++++
 tb/tb_hazard_stall_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the issue-side hazard logic: widths, NOP encoding,
// hazard causes and the bundle of pipeline register controls.
package hazard_stall_unit_pkg;

    localparam int DEF_REG_AW   = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_CNT_W    = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_MEM,
        HZ_REDIR,
        HZ_LOADUSE,
        HZ_SB,
        HZ_STRUCT
    } hazard_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                        id_ex_write: 1'b1, id_ex_bubble: 1'b0};
    localparam pipe_ctrl_t CTRL_MEM = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                        id_ex_write: 1'b0, id_ex_bubble: 1'b0};
    localparam pipe_ctrl_t CTRL_REDIR = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                          id_ex_write: 1'b1, id_ex_bubble: 1'b1};
    localparam pipe_ctrl_t CTRL_ID_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                             id_ex_write: 1'b1, id_ex_bubble: 1'b1};
    localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                          id_ex_write: 1'b1, id_ex_bubble: 1'b1};

    // A redirect discards work rather than waiting, so it is not a stall cycle.
    function automatic logic counts_as_stall(input hazard_e cause);
        return (cause == HZ_MEM) || (cause == HZ_LOADUSE) ||
               (cause == HZ_SB)  || (cause == HZ_STRUCT);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_reg_scoreboard.sv
// Pending-writer scoreboard for long-latency destinations, with a same-cycle
// write-back bypass on the two ID read ports.
module reg_scoreboard
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_set,
    input  logic [REG_AW-1:0]   i_set_rd,
    input  logic                i_clr,
    input  logic [REG_AW-1:0]   i_clr_rd,
    input  logic [REG_AW-1:0]   i_rs1,
    input  logic [REG_AW-1:0]   i_rs2,
    output logic                o_rs1_pending,
    output logic                o_rs2_pending,
    output logic [NUM_REGS-1:0] o_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_pending_nxt = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            // Set is applied after clear: a newer writer to the same rd stays pending.
            w_pending_nxt[i] = (i_set && (i_set_rd == REG_AW'(i))) ||
                               (r_pending[i] && !(i_clr && (i_clr_rd == REG_AW'(i))));
        end
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it takes the async reset directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_rs1_pending = r_pending[i_rs1] && !(i_clr && (i_clr_rd == i_rs1));
    assign o_rs2_pending = r_pending[i_rs2] && !(i_clr && (i_clr_rd == i_rs2));
    assign o_pending     = r_pending;

endmodule

// File: rtl/hazard_stall_unit.sv
// Issue-side stall/flush controller: prioritises memory wait, redirect and ID hazards
// that forwarding cannot cover, and counts stalled cycles.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                id_is_long,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_valid,
    input  logic                lop_issue,
    input  logic [REG_AW-1:0]   lop_rd,
    input  logic                lop_busy,
    input  logic                lop_done,
    input  logic [REG_AW-1:0]   lop_done_rd,
    input  logic                branch_taken,
    input  logic                dmem_ready,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_id_flush,
    output logic                id_ex_write,
    output logic                id_ex_bubble,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [NUM_REGS-1:0] sb_pending
);

    logic       w_rs1_pending;
    logic       w_rs2_pending;
    logic       w_load_use;
    logic       w_sb_hit;
    logic       w_struct;
    hazard_e    w_cause;
    pipe_ctrl_t w_ctrl;

    logic [CNT_W-1:0] r_stall_cnt;

    reg_scoreboard #(
        .REG_AW   (REG_AW),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_set         (lop_issue),
        .i_set_rd      (lop_rd),
        .i_clr         (lop_done),
        .i_clr_rd      (lop_done_rd),
        .i_rs1         (id_rs1),
        .i_rs2         (id_rs2),
        .o_rs1_pending (w_rs1_pending),
        .o_rs2_pending (w_rs2_pending),
        .o_pending     (sb_pending)
    );

    // One bubble suffices: next cycle the load sits in MEM and forwarding takes over.
    assign w_load_use = ex_valid && ex_mem_read && (ex_rd != '0) &&
                        ((id_use_rs1 && (ex_rd == id_rs1)) ||
                         (id_use_rs2 && (ex_rd == id_rs2)));
    assign w_sb_hit   = (id_use_rs1 && w_rs1_pending) || (id_use_rs2 && w_rs2_pending);
    assign w_struct   = id_is_long && lop_busy;

    always_comb begin
        w_cause = HZ_NONE;
        if (!dmem_ready) begin
            w_cause = HZ_MEM;
        end else if (branch_taken) begin
            w_cause = HZ_REDIR;
        end else if (id_valid && w_load_use) begin
            w_cause = HZ_LOADUSE;
        end else if (id_valid && w_sb_hit) begin
            w_cause = HZ_SB;
        end else if (id_valid && w_struct) begin
            w_cause = HZ_STRUCT;
        end
    end

    always_comb begin
        w_ctrl = CTRL_RUN;
        case (w_cause)
            HZ_MEM:                        w_ctrl = CTRL_MEM;
            HZ_REDIR:                      w_ctrl = CTRL_REDIR;
            HZ_LOADUSE, HZ_SB, HZ_STRUCT:  w_ctrl = CTRL_ID_STALL;
            default:                       w_ctrl = CTRL_RUN;
        endcase
        if (!rst_n) begin
            w_ctrl = CTRL_RESET;
        end
    end

    assign pc_write     = w_ctrl.pc_write;
    assign if_id_write  = w_ctrl.if_id_write;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_write  = w_ctrl.id_ex_write;
    assign id_ex_bubble = w_ctrl.id_ex_bubble;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (counts_as_stall(w_cause) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_hazard_stall_unit;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 32;

    // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble}
    localparam logic [4:0] C_RUN   = 5'b11010;
    localparam logic [4:0] C_MEM   = 5'b00000;
    localparam logic [4:0] C_REDIR = 5'b11111;
    localparam logic [4:0] C_STALL = 5'b00011;
    localparam logic [4:0] C_RST   = 5'b00111;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid, id_use_rs1, id_use_rs2, id_is_long;
    logic [REG_AW-1:0]   id_rs1, id_rs2, ex_rd, lop_rd, lop_done_rd;
    logic                ex_mem_read, ex_valid, lop_issue, lop_busy, lop_done;
    logic                branch_taken, dmem_ready;
    logic                pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic [CNT_W-1:0]    stall_cnt;
    logic [NUM_REGS-1:0] sb_pending;

    int checks = 0;
    int errors = 0;

    // Reference model state: which registers have an outstanding long-op writer,
    // and how many stalled cycles have elapsed.
    bit          m_pend [NUM_REGS];
    longint      m_cnt;

    hazard_stall_unit #(
        .REG_AW   (REG_AW),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_is_long   (id_is_long),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_valid     (ex_valid),
        .lop_issue    (lop_issue),
        .lop_rd       (lop_rd),
        .lop_busy     (lop_busy),
        .lop_done     (lop_done),
        .lop_done_rd  (lop_done_rd),
        .branch_taken (branch_taken),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_bubble (id_ex_bubble),
        .stall_cnt    (stall_cnt),
        .sb_pending   (sb_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dut_ctrl();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble};
    endfunction

    // A source register is blocked by the scoreboard if it has an outstanding
    // writer and that writer is not completing right now.
    function automatic bit model_sb_blocks(input bit used, input int rs);
        if (!used || rs == 0) return 1'b0;
        return m_pend[rs] && !(lop_done && int'(lop_done_rd) == rs);
    endfunction

    function automatic bit model_id_hazard();
        bit load_use, sb, strct;
        load_use = ex_valid && ex_mem_read && ex_rd != 0 &&
                   ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        sb       = model_sb_blocks(id_use_rs1, int'(id_rs1)) ||
                   model_sb_blocks(id_use_rs2, int'(id_rs2));
        strct    = id_is_long && lop_busy;
        return id_valid && (load_use || sb || strct);
    endfunction

    function automatic logic [4:0] model_ctrl();
        if (!rst_n)          return C_RST;
        if (!dmem_ready)     return C_MEM;
        if (branch_taken)    return C_REDIR;
        if (model_id_hazard()) return C_STALL;
        return C_RUN;
    endfunction

    function automatic logic [NUM_REGS-1:0] model_sb_vec();
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int r = 0; r < NUM_REGS; r++) v[r] = m_pend[r];
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] model_cnt_val();
        return CNT_W'(m_cnt);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) m_pend[r] = 1'b0;
        m_cnt = 0;
    endtask

    // Advance one clock: fold the current inputs into the model, then let the DUT clock.
    task automatic tick();
        bit stalled;
        stalled = !dmem_ready || (!branch_taken && model_id_hazard());
        if (stalled && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (lop_done && lop_done_rd != 0) m_pend[lop_done_rd] = 1'b0;
        if (lop_issue && lop_rd != 0)     m_pend[lop_rd] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_is_long = 0; ex_rd = 0; ex_mem_read = 0; ex_valid = 0;
        lop_issue = 0; lop_rd = 0; lop_busy = 0; lop_done = 0; lop_done_rd = 0;
        branch_taken = 0; dmem_ready = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        #3;
        checks++;
        if (dut_ctrl() !== C_RST) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected %b", dut_ctrl(), C_RST);
        end
        checks++;
        if (stall_cnt !== '0 || sb_pending !== '0) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d sb=%h expected 0/0", stall_cnt, sb_pending);
        end
        @(posedge clk);
        #2 rst_n = 1;
        #1;
        checks++;
        if (dut_ctrl() !== C_RUN) begin
            errors++;
            $display("FAIL after_reset_run got %b expected %b", dut_ctrl(), C_RUN);
        end
    endtask

    task automatic test_load_use();
        logic [CNT_W-1:0] base;
        base = stall_cnt;
        idle_inputs();
        id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
        #1;
        checks++;
        if (dut_ctrl() !== C_STALL) begin
            errors++;
            $display("FAIL load_use_stall got %b expected %b", dut_ctrl(), C_STALL);
        end
        tick();
        // The bubble now occupies ID/EX; the load has moved on to MEM.
        ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
        #1;
        checks++;
        if (dut_ctrl() !== C_RUN) begin
            errors++;
            $display("FAIL load_use_release got %b expected %b", dut_ctrl(), C_RUN);
        end
        checks++;
        if (stall_cnt !== base + 1) begin
            errors++;
            $display("FAIL load_use_cnt got %0d expected %0d", stall_cnt, base + 1);
        end
        tick();
    endtask

    task automatic test_no_stall_cases();
        idle_inputs();
        id_valid = 1; id_rs1 = 5; id_use_rs1 = 0;
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
        #1;
        checks++;
        if (dut_ctrl() !== C_RUN) begin
            errors++;
            $display("FAIL unused_rs_no_stall got %b expected %b", dut_ctrl(), C_RUN);
        end
        tick();
        id_rs1 = 0; id_use_rs1 = 1; ex_rd = 0;
        #1;
        checks++;
        if (dut_ctrl() !== C_RUN) begin
            errors++;
            $display("FAIL x0_no_stall got %b expected %b", dut_ctrl(), C_RUN);
        end
        tick();
        id_rs1 = 3; id_is_long = 1; lop_busy = 1; ex_valid = 0;
        #1;
        checks++;
        if (dut_ctrl() !== C_STALL) begin
            errors++;
            $display("FAIL structural_stall got %b expected %b", dut_ctrl(), C_STALL);
        end
        tick();
    endtask

    task automatic test_scoreboard_bypass();
        idle_inputs();
        lop_issue = 1; lop_rd = 7;
        tick();
        lop_issue = 0; lop_rd = 0;
        checks++;
        if (sb_pending[7] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set7 got %b expected 1", sb_pending[7]);
        end
        repeat (3) tick();
        id_valid = 1; id_rs2 = 7; id_use_rs2 = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (dut_ctrl() !== C_STALL) begin
                errors++;
                $display("FAIL sb_stall cycle %0d got %b expected %b", c, dut_ctrl(), C_STALL);
            end
            tick();
        end
        lop_done = 1; lop_done_rd = 7;
        #1;
        checks++;
        if (dut_ctrl() !== C_RUN) begin
            errors++;
            $display("FAIL sb_bypass got %b expected %b", dut_ctrl(), C_RUN);
        end
        tick();
        idle_inputs();
        checks++;
        if (sb_pending[7] !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear7 got %b expected 0", sb_pending[7]);
        end
    endtask

    task automatic test_set_clear_collision();
        idle_inputs();
        lop_issue = 1; lop_rd = 9;
        tick();
        lop_done = 1; lop_done_rd = 9;
        tick();
        checks++;
        if (sb_pending[9] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins9 got %b expected 1", sb_pending[9]);
        end
        lop_issue = 0;
        tick();
        idle_inputs();
        checks++;
        if (sb_pending[9] !== 1'b0) begin
            errors++;
            $display("FAIL clear9 got %b expected 0", sb_pending[9]);
        end
        lop_issue = 1; lop_rd = 0;
        tick();
        idle_inputs();
        checks++;
        if (sb_pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_never_tracked got %b expected 0", sb_pending[0]);
        end
    endtask

    task automatic test_mem_wait_redirect();
        logic [CNT_W-1:0] base;
        base = stall_cnt;
        idle_inputs();
        dmem_ready = 0; branch_taken = 1;
        id_valid = 1; ex_valid = 1; ex_mem_read = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (dut_ctrl() !== C_MEM) begin
                errors++;
                $display("FAIL mem_wait cycle %0d got %b expected %b", c, dut_ctrl(), C_MEM);
            end
            tick();
        end
        dmem_ready = 1;
        #1;
        checks++;
        if (dut_ctrl() !== C_REDIR) begin
            errors++;
            $display("FAIL redirect got %b expected %b", dut_ctrl(), C_REDIR);
        end
        tick();
        idle_inputs();
        checks++;
        if (stall_cnt !== base + 3) begin
            errors++;
            $display("FAIL mem_wait_cnt got %0d expected %0d", stall_cnt, base + 3);
        end
    endtask

    task automatic test_reset_mid_scoreboard();
        idle_inputs();
        lop_issue = 1; lop_rd = 3;
        tick();
        lop_rd = 7;
        tick();
        idle_inputs();
        checks++;
        if (sb_pending !== 32'h0000_0088) begin
            errors++;
            $display("FAIL sb_bits_3_7 got %h expected %h", sb_pending, 32'h0000_0088);
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (sb_pending !== '0 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset_state got sb=%h cnt=%0d expected 0/0", sb_pending, stall_cnt);
        end
        checks++;
        if (dut_ctrl() !== C_RST) begin
            errors++;
            $display("FAIL mid_reset_ctrl got %b expected %b", dut_ctrl(), C_RST);
        end
        @(posedge clk);
        #2 rst_n = 1;
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            id_valid     = ($urandom_range(0, 9) != 0);
            id_rs1       = REG_AW'($urandom_range(0, 7));
            id_rs2       = REG_AW'($urandom_range(0, 7));
            id_use_rs1   = $urandom_range(0, 1) != 0;
            id_use_rs2   = $urandom_range(0, 1) != 0;
            id_is_long   = ($urandom_range(0, 3) == 0);
            ex_rd        = REG_AW'($urandom_range(0, 7));
            ex_mem_read  = ($urandom_range(0, 3) == 0);
            ex_valid     = $urandom_range(0, 1) != 0;
            lop_issue    = ($urandom_range(0, 3) == 0);
            lop_rd       = REG_AW'($urandom_range(0, 7));
            lop_busy     = ($urandom_range(0, 3) == 0);
            lop_done     = ($urandom_range(0, 2) == 0);
            lop_done_rd  = REG_AW'($urandom_range(0, 7));
            branch_taken = ($urandom_range(0, 7) == 0);
            dmem_ready   = ($urandom_range(0, 6) != 0);
            #1;
            checks++;
            if (dut_ctrl() !== model_ctrl()) begin
                errors++;
                $display("FAIL rand_ctrl n=%0d got %b expected %b", n, dut_ctrl(), model_ctrl());
            end
            checks++;
            if (sb_pending !== model_sb_vec()) begin
                errors++;
                $display("FAIL rand_sb n=%0d got %h expected %h", n, sb_pending, model_sb_vec());
            end
            checks++;
            if (stall_cnt !== model_cnt_val()) begin
                errors++;
                $display("FAIL rand_cnt n=%0d got %0d expected %0d", n, stall_cnt, model_cnt_val());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall_cases();
        test_scoreboard_bypass();
        test_set_clear_collision();
        test_mem_wait_redirect();
        test_reset_mid_scoreboard();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
